pollard_exp_sequencer: RTL
==========================

// Module: pollard_exp_sequencer
// PURPOSE
//  Sequences the shared BinaryExponentiation engine for the Pollard p-1 stage sweep.
//  For k = 2..bound it launches base^k, waits for isDone, and hands each result downstream
//  (gcd stage) over a valid/ready handshake. It owns the engine's start pulse, the base and
//  exponent operands, and a per-launch timeout watchdog.
// PARAMETERS
//  BASE_W   9    width of base operand
//  EXP_W    8    width of exponent / bound / sweep counter
//  RES_W    100  width of engine result
//  SETTLE   2    cycles after launch before engine isDone is trusted (masks stale done)
//  TIMEOUT  255  max WAIT cycles per launch before error
// PORTS
//  clk           in   1       system clock, rising edge
//  reset         in   1       asynchronous, active-low reset
//  start         in   1       1-cycle request; begins a sweep; ignored while busy=1
//  base_in       in   BASE_W  sweep base, latched on accepted start
//  bound         in   EXP_W   last exponent (inclusive), latched on accepted start
//  exp_base      out  BASE_W  engine base operand
//  exp_exponent  out  EXP_W   engine exponent operand
//  exp_start     out  1       engine restart pulse (drives engine active-high reset)
//  exp_result    in   RES_W   engine result
//  exp_done      in   1       engine isDone
//  res_valid     out  1       result available downstream
//  res_ready     in   1       downstream accepts
//  res_data      out  RES_W   captured base^k
//  res_exponent  out  EXP_W   k belonging to res_data
//  busy          out  1       high from accepted start until done/error
//  done          out  1       1-cycle pulse: sweep completed
//  timeout_err   out  1       sticky: engine failed to finish within TIMEOUT
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; all outputs 0; k, counters cleared. Mid-sweep reset aborts
//   immediately; no res_valid/done is produced for the aborted sweep.
//  FSM: IDLE -> LAUNCH -> WAIT -> PRESENT -> (LAUNCH | FINISH) -> IDLE; WAIT -> ERROR.
//  IDLE: start=1 latches base_in, bound, sets k=2, clears timeout_err, busy=1 next cycle.
//   If bound<2: go to FINISH directly, no exp_start ever issued.
//  LAUNCH (1 cycle): exp_base=latched base, exp_exponent=k, exp_start=1. Operands are driven
//   from LAUNCH and held stable through WAIT. Wait counter cleared.
//  WAIT: counter increments each cycle; exp_done sampled only when counter>=SETTLE.
//   Trusted exp_done=1 -> capture res_data=exp_result, res_exponent=k; go PRESENT.
//   counter reaches TIMEOUT without trusted done -> ERROR.
//  PRESENT: res_valid=1; res_data/res_exponent stable while res_valid&&!res_ready.
//   Transfer when res_valid&&res_ready in same cycle; res_valid drops next cycle.
//   After transfer: k==bound -> FINISH, else k<=k+1 and -> LAUNCH.
//   Compare before increment: bound=255 ends at k=255, k never wraps.
//  FINISH (1 cycle): done=1, busy=0 next cycle, -> IDLE.
//  ERROR: timeout_err=1 (sticky), busy=0, exp_start=0; -> IDLE same cycle. Cleared by next
//   accepted start or reset. No done pulse on error.
//  start while busy: ignored, no effect on latched operands.
//  Min latency per exponent: LAUNCH(1)+WAIT(>=SETTLE+1)+PRESENT(>=1) cycles.
//  Results are carried full width (RES_W); no modular reduction in this block.
// TESTING
//  1 base_in=3,bound=5,ready=1 -> 4 transfers (k,data)=(2,9),(3,27),(4,81),(5,243); 1 done pulse.
//  2 base_in=2,bound=4, res_ready low 10 cycles per result -> res_data/res_exponent held
//    stable; no relaunch until handshake; results 4,8,16.
//  3 bound=1 -> done pulse 2 cycles after start; exp_start never asserted; no res_valid.
//  4 engine model never raises exp_done -> timeout_err=1 after TIMEOUT WAIT cycles; busy=0;
//    no done. Next start clears timeout_err.
//  5 stale exp_done=1 held during LAUNCH and first SETTLE-1 WAIT cycles -> not captured;
//    true done later is captured.
//  6 reset low mid-WAIT at k=3 -> all outputs 0 immediately. Later start base 5, bound 2 ->
//    single result 25, done.

Source files
------------

// File: rtl/pollard_exp_sequencer.sv
// Pollard p-1 stage sweep sequencer: launches base^k on the shared exponentiation engine
// for k = 2..bound, guards each launch with a watchdog, and streams results downstream.
module pollard_exp_sequencer #(
    parameter int unsigned BASE_W  = 9,
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned RES_W   = 100,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BASE_W-1:0] base_in,
    input  logic [EXP_W-1:0]  bound,
    output logic [BASE_W-1:0] exp_base,
    output logic [EXP_W-1:0]  exp_exponent,
    output logic              exp_start,
    input  logic [RES_W-1:0]  exp_result,
    input  logic              exp_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [EXP_W-1:0]  res_exponent,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_PRESENT,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t            state, state_n;
    logic [BASE_W-1:0] base_q, base_n;
    logic [EXP_W-1:0]  bound_q, bound_n;
    logic [EXP_W-1:0]  k, k_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [BASE_W-1:0] exp_base_n;
    logic [EXP_W-1:0]  exp_exponent_n;
    logic              exp_start_n;
    logic              res_valid_n;
    logic [RES_W-1:0]  res_data_n;
    logic [EXP_W-1:0]  res_exponent_n;
    logic              busy_n;
    logic              done_n;
    logic              timeout_err_n;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            base_q       <= '0;
            bound_q      <= '0;
            k            <= '0;
            cnt          <= '0;
            exp_base     <= '0;
            exp_exponent <= '0;
            exp_start    <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_exponent <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_n;
            base_q       <= base_n;
            bound_q      <= bound_n;
            k            <= k_n;
            cnt          <= cnt_n;
            exp_base     <= exp_base_n;
            exp_exponent <= exp_exponent_n;
            exp_start    <= exp_start_n;
            res_valid    <= res_valid_n;
            res_data     <= res_data_n;
            res_exponent <= res_exponent_n;
            busy         <= busy_n;
            done         <= done_n;
            timeout_err  <= timeout_err_n;
        end
    end

    // Next state; outputs are decoded from the next state so they line up with the state
    always_comb begin
        state_n        = state;
        base_n         = base_q;
        bound_n        = bound_q;
        k_n            = k;
        cnt_n          = cnt;
        exp_base_n     = exp_base;
        exp_exponent_n = exp_exponent;
        res_data_n     = res_data;
        res_exponent_n = res_exponent;
        busy_n         = busy;
        timeout_err_n  = timeout_err;
        done_n         = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    base_n        = base_in;
                    bound_n       = bound;
                    k_n           = EXP_W'(2);
                    timeout_err_n = 1'b0;
                    busy_n        = 1'b1;
                    state_n       = (bound < EXP_W'(2)) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_n   = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // Engine done is only trusted once the settle window has passed
                if (cnt >= CNT_W'(SETTLE) && exp_done) begin
                    res_data_n     = exp_result;
                    res_exponent_n = k;
                    state_n        = S_PRESENT;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_n = S_ERROR;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_PRESENT: begin
                if (res_valid && res_ready) begin
                    if (k == bound_q) begin
                        state_n = S_FINISH;
                    end else begin
                        k_n     = k + EXP_W'(1);
                        state_n = S_LAUNCH;
                    end
                end
            end
            S_FINISH: begin
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            S_ERROR: begin
                busy_n        = 1'b0;
                timeout_err_n = 1'b1;
                state_n       = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        exp_start_n = (state_n == S_LAUNCH);
        res_valid_n = (state_n == S_PRESENT);
        if (state_n == S_LAUNCH) begin
            exp_base_n     = base_n;
            exp_exponent_n = k_n;
        end
    end

endmodule
